// File: rtl/butterfly_digit_router.sv
// K-in/K-out wormhole router for one butterfly stage.
// Routes on one base-K digit of dest; credit flow control both ways.
module butterfly_digit_router #(
  parameter int K                 = 2,
  parameter int DIGIT             = 0,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int DOWNSTREAM_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [K*FLIT_WIDTH-1:0] data_in,
  input  logic [K*DEST_WIDTH-1:0] dest_in,
  input  logic [K-1:0]            is_tail_in,
  input  logic [K-1:0]            send_in,
  output logic [K-1:0]            credit_out,
  output logic [K*FLIT_WIDTH-1:0] data_out,
  output logic [K*DEST_WIDTH-1:0] dest_out,
  output logic [K-1:0]            is_tail_out,
  output logic [K-1:0]            send_out,
  input  logic [K-1:0]            credit_in,
  output logic [K-1:0]            overflow_err
);

  localparam int IW  = (K > 1) ? $clog2(K) : 1;
  localparam int PW  = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int NW  = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int CW  = $clog2(DOWNSTREAM_DEPTH + 1);
  localparam int EW  = 1 + DEST_WIDTH + FLIT_WIDTH;
  localparam int DIV = K ** DIGIT;

  logic [EW-1:0] mem    [K][FLIT_BUFFER_DEPTH];
  logic [PW-1:0] rd_ptr [K];
  logic [PW-1:0] wr_ptr [K];
  logic [NW-1:0] count  [K];
  logic [EW-1:0] head   [K];
  logic [IW-1:0] req    [K];
  logic [K-1:0]  empty;
  logic [K-1:0]  full;
  logic [K-1:0]  wr;
  logic [K-1:0]  deq;

  logic [K-1:0]  lock_valid;
  logic [IW-1:0] lock_in  [K];
  logic [IW-1:0] rr_ptr   [K];
  logic [CW-1:0] credit   [K];
  logic [K-1:0]  grant;
  logic [IW-1:0] grant_in [K];
  logic [EW-1:0] gflit    [K];

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    if (int'(p) == FLIT_BUFFER_DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  function automatic logic [IW-1:0] route(input logic [DEST_WIDTH-1:0] d);
    return IW'((int'(d) / DIV) % K);
  endfunction

  // Inputs holding a lock request their locked output, not the dest digit
  always_comb begin
    for (int i = 0; i < K; i++) begin
      empty[i] = (count[i] == '0);
      full[i]  = (count[i] == NW'(FLIT_BUFFER_DEPTH));
      head[i]  = mem[i][rd_ptr[i]];
      req[i]   = route(head[i][FLIT_WIDTH +: DEST_WIDTH]);
      for (int o = 0; o < K; o++)
        if (lock_valid[o] && lock_in[o] == IW'(i))
          req[i] = IW'(o);
    end
  end

  always_comb begin
    logic [IW-1:0] sel;
    sel   = '0;
    grant = '0;
    deq   = '0;
    for (int o = 0; o < K; o++) begin
      grant_in[o] = '0;
      if (credit[o] != '0) begin
        if (lock_valid[o]) begin
          grant[o]    = !empty[lock_in[o]];
          grant_in[o] = lock_in[o];
        end else begin
          for (int j = 0; j < K; j++) begin
            sel = IW'((int'(rr_ptr[o]) + j) % K);
            if (!grant[o] && !empty[sel] && req[sel] == IW'(o)) begin
              grant[o]    = 1'b1;
              grant_in[o] = sel;
            end
          end
        end
      end
      gflit[o] = head[grant_in[o]];
      if (grant[o]) deq[grant_in[o]] = 1'b1;
    end
    for (int i = 0; i < K; i++)
      wr[i] = send_in[i] && (!full[i] || deq[i]);
  end

  assign credit_out = deq;

  always_ff @(posedge clk) begin
    for (int i = 0; i < K; i++)
      if (wr[i])
        mem[i][wr_ptr[i]] <= {is_tail_in[i],
                              dest_in[i*DEST_WIDTH +: DEST_WIDTH],
                              data_in[i*FLIT_WIDTH +: FLIT_WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= '0;
      for (int i = 0; i < K; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < K; i++) begin
        if (wr[i])  wr_ptr[i] <= bump(wr_ptr[i]);
        if (deq[i]) rd_ptr[i] <= bump(rd_ptr[i]);
        count[i] <= count[i] + NW'(wr[i]) - NW'(deq[i]);
        if (send_in[i] && full[i] && !deq[i])
          overflow_err[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= '0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= '0;
      lock_valid  <= '0;
      for (int o = 0; o < K; o++) begin
        lock_in[o] <= '0;
        rr_ptr[o]  <= '0;
        credit[o]  <= CW'(DOWNSTREAM_DEPTH);
      end
    end else begin
      send_out <= grant;
      for (int o = 0; o < K; o++) begin
        if (grant[o]) begin
          data_out[o*FLIT_WIDTH +: FLIT_WIDTH] <= gflit[o][FLIT_WIDTH-1:0];
          dest_out[o*DEST_WIDTH +: DEST_WIDTH] <=
            gflit[o][FLIT_WIDTH +: DEST_WIDTH];
          is_tail_out[o] <= gflit[o][EW-1];
          if (gflit[o][EW-1]) begin
            lock_valid[o] <= 1'b0;
            rr_ptr[o]     <= IW'((int'(grant_in[o]) + 1) % K);
          end else begin
            lock_valid[o] <= 1'b1;
            lock_in[o]    <= grant_in[o];
          end
        end
        // Saturate so a spurious extra credit cannot wrap the count
        if (grant[o] && !credit_in[o])
          credit[o] <= credit[o] - CW'(1);
        else if (!grant[o] && credit_in[o] &&
                 credit[o] != CW'(DOWNSTREAM_DEPTH))
          credit[o] <= credit[o] + CW'(1);
      end
    end
  end

endmodule

// File: doc/butterfly_digit_router.md
Name: butterfly_digit_router

Overview:
- K-input, K-output wormhole router for one stage of a k-ary n-fly butterfly.
- Routes on one base-K digit of the destination field, so no routing-table hex file is needed.
- Per-input flit FIFOs with credit-based flow control toward upstream.
- Per-output downstream credit counters, round-robin arbitration with packet locking, and registered outputs.
- The next-generation butterfly NoC top instantiates it once per router position, with DIGIT set to the stage index.

Parameters:
- K, 2, radix: number of input ports and number of output ports.
- DIGIT, 0, base-K digit of dest used for routing; output port = (dest / K**DIGIT) mod K.
- DEST_WIDTH, 4, width of the destination field.
- FLIT_WIDTH, 256, width of the data payload.
- FLIT_BUFFER_DEPTH, 2, entries per input FIFO (>=1).
- DOWNSTREAM_DEPTH, 2, initial credit count per output; equals the downstream FIFO depth (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  [FLIT_WIDTH] x K  flit payload per input
- dest_in  in  [DEST_WIDTH] x K  destination per input
- is_tail_in  in  1 x K  last flit of packet
- send_in  in  1 x K  flit valid, one flit per cycle
- credit_out  out  1 x K  one-cycle pulse per input FIFO dequeue
- data_out  out  [FLIT_WIDTH] x K  registered payload per output
- dest_out  out  [DEST_WIDTH] x K  registered destination per output
- is_tail_out  out  1 x K  registered tail flag per output
- send_out  out  1 x K  one-cycle valid pulse per output
- credit_in  in  1 x K  one-cycle pulse per credit returned by downstream
- overflow_err  out  1 x K  sticky: send_in was seen while that input FIFO was full

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0; FIFOs empty.
  - Credit counters = DOWNSTREAM_DEPTH.
  - All locks cleared; round-robin pointers = 0; overflow_err = 0.
  - Reset asserted mid-packet discards every in-flight flit and lock; no credits are returned for discarded flits.
- Input FIFO:
  - send_in=1 writes {data,dest,tail} at the clock edge.
  - If the FIFO is full at that edge, the flit is dropped and overflow_err[i] is set. It stays set until reset.
  - Simultaneous write and dequeue on a full FIFO is legal, and the write is not flagged.
- Route compute:
  - The head flit of input i requests output o = (dest / K**DIGIT) mod K.
  - The head flit is the first flit after reset or after a tail.
  - Body and tail flits follow the locked output. Their dest field is ignored for routing but is forwarded unchanged.
- Arbitration, per output o, combinational each cycle:
  - Eligible only if o is unlocked and credit[o] > 0.
  - Candidates are inputs with a non-empty FIFO whose head flit routes to o.
  - Grant goes to the first candidate at or after rr_ptr[o], modulo K.
  - A grant on a non-tail flit locks o to input i.
  - While locked, o serves only input i, whenever its FIFO is non-empty and credit[o] > 0.
  - An output may be idle even when a locked input is empty.
- Transfer in the grant cycle:
  - The flit is dequeued and credit_out[i]=1 for that cycle.
  - The output registers load the flit; send_out[o]=1 in the next cycle.
  - credit[o] decrements.
- Tail transfer: the lock on o is cleared and rr_ptr[o] = i+1 mod K.
- A single-flit packet (head is also tail) never locks the output and still advances rr_ptr[o].
- Latency: send_in at edge t gives the earliest send_out at edge t+2, with credit_out[i] at cycle t+1.
- Credit counter, width clog2(DOWNSTREAM_DEPTH+1):
  - Send and credit_in in the same cycle: unchanged.
  - Send only: -1. credit_in only: +1.
  - credit_in at full count: saturates, no wrap.
- Each input is granted to at most one output per cycle; each output sends at most one flit per cycle.
- send_out deasserted: data_out, dest_out and is_tail_out hold their last values.

Test Plan:
- K=2, DIGIT=1, dest_in[0]=4'b0010 single-flit packet at cycle 0 → send_out[1]=1 at cycle 2 with dest_out=4'b0010; credit_out[0]=1 at cycle 1.
- Inputs 0 and 1 each send 3-flit packets to output 0 in the same cycle → input 0's three flits go out contiguously, then input 1's. A repeat of the same stimulus starts with input 1.
- DOWNSTREAM_DEPTH=2, no credit_in, 4 single-flit packets to output 0 → exactly 2 send_out pulses. One credit_in pulse → exactly one more flit, 2 cycles later.
- FLIT_BUFFER_DEPTH=2, credit_in held 0 with the output exhausted, 3 flits sent on input 0 → overflow_err[0]=1 after the third flit and stays 1. The 2 buffered flits drain after credits return.
- credit_in and send_out in the same cycle with credit=1 → counter stays at 1, next flit is not stalled.
- rst_n pulsed low for 1 cycle while a 4-flit packet is locked on output 1 → all outputs 0 immediately, credits = DOWNSTREAM_DEPTH. A new packet from input 0 is then granted normally.
